rr_arbiter_8: RTL and testbench



---
 rtl/rr_arbiter_8_pkg.sv | 8 +
 rtl/rr_arbiter_8_if.sv | 12 +
 rtl/rr_arbiter_8_pick.sv | 22 ++
 rtl/rr_arbiter_8.sv | 76 +++++++
 tb/tb_rr_arbiter_8.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// arb_pkg: shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int ID_W  = 3;
    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [ID_W-1:0]  req_id_t;
endpackage

// File: rtl/rr_arbiter_8_if.sv
// rr_arbiter_8_if: request/release and grant bundle between requesters and the arbiter.
interface rr_arbiter_8_if;
    import arb_pkg::*;
    req_vec_t req;
    logic     done;
    req_vec_t grant;
    req_id_t  grant_id;
    logic     grant_valid;
    logic     timeout;
    modport master (output req, done, input grant, grant_id, grant_valid, timeout);
    modport slave  (input req, done, output grant, grant_id, grant_valid, timeout);
endinterface

// File: rtl/rr_arbiter_8_pick.sv
// rr_pick_8: combinational round-robin winner search starting at ptr.
module rr_pick_8
    import arb_pkg::*;
(
    input  req_vec_t req,
    input  req_id_t  ptr,
    output req_id_t  win,
    output logic     any_req
);
    logic [2*N_REQ-1:0] dbl;
    req_vec_t           rot;
    req_id_t            off;
    // rotate so ptr lands on bit 0, find lowest set bit, then undo the rotation
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) off = req_id_t'(i);
        win     = off + ptr;
        any_req = |req;
    end
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter holding each grant until release.
// Define RR_ARB_TIMEOUT_EN to force-revoke grants held for MAX_HOLD cycles.
module rr_arbiter_8
    import arb_pkg::*;
`ifdef RR_ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 16
)
`endif
(
    input logic          clk,
    input logic          rst_n,
    rr_arbiter_8_if.slave bus
);
    arb_state_t state_q, state_d;
    req_id_t    ptr_q, ptr_d, id_q, id_d, win;
    logic       any_req, rel, forced, timeout_q, timeout_d;
`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
`endif

    rr_pick_8 u_pick (.req(bus.req), .ptr(ptr_q), .win(win), .any_req(any_req));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            timeout_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            timeout_q <= timeout_d;
`ifdef RR_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
`endif
        end
    end

    always_comb begin
        rel = bus.done | ~bus.req[id_q];
`ifdef RR_ARB_TIMEOUT_EN
        forced = hold_q == 8'(MAX_HOLD - 1);
        hold_d = state_q == GRANT ? hold_q + 8'd1 : 8'd0;
`else
        forced = 1'b0;
`endif
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (any_req) begin
                state_d = GRANT;
                id_d    = win;
            end
        end else if (rel | forced) begin
            // a normal release outranks a simultaneous forced one
            state_d   = IDLE;
            id_d      = '0;
            ptr_d     = id_q + 3'd1;
            timeout_d = forced & ~rel;
        end
    end

    always_comb begin
        bus.grant_valid = state_q == GRANT;
        bus.grant_id    = id_q;
        bus.grant       = state_q == GRANT ? req_vec_t'(1) << id_q : '0;
        bus.timeout     = timeout_q;
    end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed and randomized checks of rr_arbiter_8 against a queue-free owner/priority model.
// Build with RR_ARB_TIMEOUT_EN to exercise forced revocation at MAX_HOLD = 4.
module tb_rr_arbiter_8;
    import arb_pkg::*;
`ifdef RR_ARB_TIMEOUT_EN
    localparam int MH    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MH    = 16;
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    rr_arbiter_8_if bus ();

`ifdef RR_ARB_TIMEOUT_EN
    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`else
    rr_arbiter_8 dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int owner  = -1;
    int prio   = 0;
    int hold   = 0;
    bit to_exp = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void model_reset();
        owner  = -1;
        prio   = 0;
        hold   = 0;
        to_exp = 1'b0;
    endfunction

    // owner = index holding the resource (-1 idle), prio = first index searched next
    task automatic model_step(input req_vec_t r, input logic d);
        to_exp = 1'b0;
        if (owner < 0) begin
            for (int k = 0; k < 8; k++) begin
                int c = (prio + k) % 8;
                if (r[c]) begin
                    owner = c;
                    hold  = 0;
                    break;
                end
            end
        end else begin
            bit rel = d || !r[owner];
            bit frc = TO_EN && (hold == MH - 1);
            if (rel || frc) begin
                prio   = (owner + 1) % 8;
                to_exp = frc && !rel;
                owner  = -1;
            end else hold++;
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".valid"},   int'(bus.grant_valid), int'(owner >= 0));
        chk({tag, ".grant"},   int'(bus.grant),       owner < 0 ? 0 : (1 << owner));
        chk({tag, ".id"},      int'(bus.grant_id),    owner < 0 ? 0 : owner);
        chk({tag, ".timeout"}, int'(bus.timeout),     int'(to_exp));
    endtask

    task automatic cyc(input req_vec_t r, input logic d, input string tag);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_step(r, d);
        #1 check_outs(tag);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        model_reset();
        #1 check_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int       ids[$];
    req_vec_t cur;

    initial begin
        bus.req  = '0;
        bus.done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outs("por");
        rst_n = 1'b1;
        repeat (5) cyc(8'h00, 1'b0, "idle");

        cyc(8'h20, 1'b0, "r5_grant");
        chk("r5_id", int'(bus.grant_id), 5);
        cyc(8'h20, 1'b0, "r5_hold");
        cyc(8'h20, 1'b0, "r5_hold");
        cyc(8'h20, 1'b1, "r5_done");
        chk("r5_release", int'(bus.grant), 0);
        cyc(8'h61, 1'b0, "ptr6");
        chk("ptr6_id", int'(bus.grant_id), 6);
        cyc(8'h00, 1'b0, "ptr6_drop");

        do_reset();
        for (int i = 0; i < 18; i++) begin
            cyc(8'hFF, 1'b1, "fair");
            chk("fair_bubble", int'(bus.grant_valid), int'(i % 2 == 0));
            if (bus.grant_valid) ids.push_back(int'(bus.grant_id));
        end
        chk("fair_count", ids.size(), 9);
        foreach (ids[k]) chk("fair_order", ids[k], k % 8);

        do_reset();
        cyc(8'h08, 1'b0, "o3_grant");
        cyc(8'h08, 1'b0, "o3_hold");
        cyc(8'h05, 1'b0, "o3_drop");
        chk("o3_cleared", int'(bus.grant_valid), 0);
        cyc(8'h05, 1'b0, "o3_next");
        chk("wrap_id", int'(bus.grant_id), 0);
        cyc(8'h00, 1'b0, "o3_idle");

        do_reset();
        cyc(8'h80, 1'b0, "r7_grant");
        chk("r7_grant_val", int'(bus.grant), 8'h80);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outs("async_rst");
        chk("async_rst_grant", int'(bus.grant), 0);
        #2 bus.req = 8'h81;
        rst_n = 1'b1;
        cyc(8'h81, 1'b0, "after_rst");
        chk("after_rst_id", int'(bus.grant_id), 0);
        chk("after_rst_valid", int'(bus.grant_valid), 1);

`ifdef RR_ARB_TIMEOUT_EN
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            cyc(8'h04, 1'b0, "to");
            chk("to_valid", int'(bus.grant_valid), int'(i != 5));
            chk("to_pulse", int'(bus.timeout), int'(i == 5));
        end
`endif

        do_reset();
        cur = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) cur = req_vec_t'($urandom);
            cyc(cur, logic'($urandom_range(0, 3) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
